bcd_serial_adder: RTL and testbench

- Digit-serial multi-digit BCD adder sequencer. It sits upstream of, and wraps, the single-digit BCD add stage (4-bit a/b digits plus cin, producing a decimal carry and a 4-bit digit).
- Each cycle it feeds one digit pair, least-significant digit first, through a one-digit BCD add.
- It registers the carry between digits and assembles the packed multi-digit BCD result.
- A start/busy/done handshake connects it to the controlling logic.

---
 rtl/bcd_serial_adder.sv | 123 ++++++++++++
 tb/tb_bcd_serial_adder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial multi-digit BCD adder sequencer
// One digit pair per cycle, LSD first; carry registered between digits.
module bcd_serial_adder #(
  parameter int DIGITS = 4,
  parameter int CW     = $clog2(DIGITS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [4*DIGITS-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                cout_q, cout_d, err_q, err_d, done_q, done_d;

  logic [3:0] a_dig, b_dig, dig;
  logic [4:0] s;
  logic       c_nx, last;

  // Single-digit BCD add stage on the currently indexed digit pair
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == CW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
    s = 5'(a_dig) + 5'(b_dig) + 5'(carry_q);
    if (s >= 5'd10) begin
      dig  = s[3:0] + 4'd6;
      c_nx = 1'b1;
    end else begin
      dig  = s[3:0];
      c_nx = 1'b0;
    end
    last = (idx_q == CW'(DIGITS - 1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == CW'(i)) sum_d[4*i +: 4] = dig;
        end
        carry_d = c_nx;
        if (a_dig > 4'd9 || b_dig > 4'd9) err_d = 1'b1;
        if (last) begin
          cout_d  = c_nx;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - self-checking bench for bcd_serial_adder
// Random and directed operations checked against a decimal reference model.
module tb_bcd_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done, cout, err;
  logic [15:0] sum;

  logic       start1, cin1, busy1, done1, cout1, err1;
  logic [3:0] a1, b1, sum1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  bcd_serial_adder #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
  );

  // Valid operands: plain decimal arithmetic. Invalid digits: per-digit rule.
  function automatic void model(input logic [15:0] aa, input logic [15:0] bb, input logic ci,
                                output logic [15:0] es, output logic ec, output logic ee);
    int va, vb, tot, c, sd, ad, bd;
    ee = 1'b0;
    for (int i = 0; i < 4; i++)
      if (aa[4*i +: 4] > 4'd9 || bb[4*i +: 4] > 4'd9) ee = 1'b1;
    es = '0;
    if (!ee) begin
      va = 0; vb = 0;
      for (int i = 3; i >= 0; i--) begin
        va = va * 10 + int'(aa[4*i +: 4]);
        vb = vb * 10 + int'(bb[4*i +: 4]);
      end
      tot = va + vb + int'(ci);
      ec  = (tot >= 10000);
      tot = tot % 10000;
      for (int i = 0; i < 4; i++) begin
        es[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      c = int'(ci);
      for (int i = 0; i < 4; i++) begin
        ad = int'(aa[4*i +: 4]);
        bd = int'(bb[4*i +: 4]);
        sd = ad + bd + c;
        if (sd >= 10) begin sd = (sd + 6) % 16; c = 1; end
        else c = 0;
        es[4*i +: 4] = 4'(sd);
      end
      ec = c[0];
    end
  endfunction

  // Starts an op and returns at the negedge where done is seen (or on timeout).
  task automatic do_op(input logic [15:0] aa, input logic [15:0] bb, input logic ci,
                       output int busy_cycles, output bit got_done);
    @(negedge clk);
    a = aa; b = bb; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    busy_cycles = 0;
    got_done = 0;
    for (int t = 0; t < 20 && !got_done; t++) begin
      if (done) got_done = 1;
      else begin
        if (busy) busy_cycles++;
        @(negedge clk);
      end
    end
  endtask

  task automatic check_op(input string name, input logic [15:0] aa, input logic [15:0] bb,
                          input logic ci);
    logic [15:0] es; logic ec, ee;
    int bc; bit gd;
    model(aa, bb, ci, es, ec, ee);
    do_op(aa, bb, ci, bc, gd);
    checks++;
    if (!gd) begin errors++; $display("FAIL %s done timeout: got no done, expected done", name); end
    checks++;
    if ({sum, cout, err} !== {es, ec, ee}) begin
      errors++;
      $display("FAIL %s result: a=%h b=%h cin=%0d got sum=%h cout=%0d err=%0d expected sum=%h cout=%0d err=%0d",
               name, aa, bb, ci, sum, cout, err, es, ec, ee);
    end
    checks++;
    if (bc !== 4) begin errors++; $display("FAIL %s busy_cycles: got %0d expected 4", name, bc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %0d expected 0", name, busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_width: got %0d expected 0", name, done); end
    checks++;
    if ({sum, cout, err} !== {es, ec, ee}) begin
      errors++; $display("FAIL %s hold: got sum=%h expected %h", name, sum, es);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; a = 0; b = 0; cin = 0; start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    #12;
    checks++;
    if ({busy, done, sum, cout, err} !== 20'h0) begin
      errors++; $display("FAIL reset: got busy=%0d done=%0d sum=%h cout=%0d err=%0d expected all 0",
                         busy, done, sum, cout, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    check_op("plan_1234_5678", 16'h1234, 16'h5678, 1'b0);
    check_op("ripple_9999_1", 16'h9999, 16'h0001, 1'b0);
    check_op("nines_cin", 16'h9999, 16'h9999, 1'b1);
    check_op("small_cin", 16'h0009, 16'h0009, 1'b1);
    check_op("zero", 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic test_err_clear();
    check_op("err_00A0", 16'h00A0, 16'h0000, 1'b0);
    checks++;
    if (sum !== 16'h0100 || err !== 1'b1) begin
      errors++; $display("FAIL err_value: got sum=%h err=%0d expected sum=0100 err=1", sum, err);
    end
    check_op("err_cleared", 16'h0421, 16'h0310, 1'b0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_sticky_clear: got %0d expected 0", err); end
  endtask

  task automatic test_random();
    logic [15:0] ra, rb;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 3) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      check_op("random", ra, rb, 1'($urandom));
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] es; logic ec, ee;
    int dcount;
    model(16'h2718, 16'h3141, 1'b1, es, ec, ee);
    @(negedge clk);
    a = 16'h2718; b = 16'h3141; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    a = 16'h9999; b = 16'h9999; start = 1'b0;
    dcount = 0;
    for (int t = 0; t < 12; t++) begin
      start = (t == 0 || t == 2);
      if (done) begin
        dcount++;
        checks++;
        if ({sum, cout} !== {es, ec}) begin
          errors++; $display("FAIL busy_ignore result: got sum=%h cout=%0d expected sum=%h cout=%0d",
                             sum, cout, es, ec);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (dcount !== 1) begin errors++; $display("FAIL busy_ignore done_count: got %0d expected 1", dcount); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e1, e2; logic c1, c2, x1, x2;
    bit gd;
    model(16'h4567, 16'h5555, 1'b0, e1, c1, x1);
    model(16'h0808, 16'h0303, 1'b1, e2, c2, x2);
    @(negedge clk);
    a = 16'h4567; b = 16'h5555; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h0808; b = 16'h0303; cin = 1'b1;
    gd = 0;
    for (int t = 0; t < 10 && !gd; t++) begin
      if (done) gd = 1; else @(negedge clk);
    end
    checks++;
    if (!gd || {sum, cout} !== {e1, c1}) begin
      errors++; $display("FAIL b2b first: got done=%0d sum=%h cout=%0d expected sum=%h cout=%0d",
                         gd, sum, cout, e1, c1);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b restart: got done=%0d busy=%0d expected done=0 busy=1", done, busy);
    end
    gd = 0;
    for (int t = 0; t < 10 && !gd; t++) begin
      if (done) gd = 1; else @(negedge clk);
    end
    checks++;
    if (!gd || {sum, cout} !== {e2, c2}) begin
      errors++; $display("FAIL b2b second: got done=%0d sum=%h cout=%0d expected sum=%h cout=%0d",
                         gd, sum, cout, e2, c2);
    end
  endtask

  task automatic test_reset_midop();
    int dcount;
    @(negedge clk);
    a = 16'h123A; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout, err} !== 20'h0) begin
      errors++; $display("FAIL reset_midop: got busy=%0d sum=%h cout=%0d err=%0d expected all 0",
                         busy, sum, cout, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int t = 0; t < 8; t++) begin
      if (done || busy) dcount++;
      @(negedge clk);
    end
    checks++;
    if (dcount !== 0) begin errors++; $display("FAIL reset_no_done: got %0d active cycles expected 0", dcount); end
    check_op("after_reset", 16'h1234, 16'h5678, 1'b0);
  endtask

  task automatic test_single_digit();
    logic [3:0] x, y; logic c; int tot;
    for (int n = 0; n < 6; n++) begin
      x = 4'($urandom_range(0, 9)); y = 4'($urandom_range(0, 9)); c = 1'($urandom);
      tot = int'(x) + int'(y) + int'(c);
      @(negedge clk);
      a1 = x; b1 = y; cin1 = c; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++; $display("FAIL d1 busy: got busy=%0d done=%0d expected busy=1 done=0", busy1, done1);
      end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== 4'(tot % 10) || cout1 !== (tot >= 10) || err1 !== 1'b0) begin
        errors++; $display("FAIL d1 result: %0d+%0d+%0d got done=%0d sum=%h cout=%0d expected sum=%0d cout=%0d",
                           x, y, c, done1, sum1, cout1, tot % 10, tot >= 10);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_err_clear();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    test_single_digit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
